// File: rtl/dcache_write_buffer_if.sv
// rtl/dcache_write_buffer_if.sv - cache-side and memory-side buses of the write buffer
// slave is the buffer's view; master is the cache/memory environment's view.
interface dcache_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              DM_READ;
  logic              DM_WRITE;
  logic [ADDR_W-1:0] DM_ADDRESS;
  logic [DATA_W-1:0] DM_WRITEDATA;
  logic [DATA_W-1:0] DM_READDATA;
  logic              DM_BUSYWAIT;
  logic [CNT_W-1:0]  WB_COUNT;
  logic              WB_EMPTY;

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, DM_READDATA, DM_BUSYWAIT,
    output MEM_READDATA, MEM_BUSYWAIT, DM_READ, DM_WRITE, DM_ADDRESS, DM_WRITEDATA,
           WB_COUNT, WB_EMPTY
  );

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, DM_READDATA, DM_BUSYWAIT,
    input  MEM_READDATA, MEM_BUSYWAIT, DM_READ, DM_WRITE, DM_ADDRESS, DM_WRITEDATA,
           WB_COUNT, WB_EMPTY
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - posted-write FIFO between dcache and data_memory
// Absorbs writebacks, forwards read hits, and lets read misses overtake pending drains.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic                 CLK,
  input logic                 RESET,
  dcache_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RD, S_RD_DONE} state_t;

  state_t            r_state, w_next;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rdata;

  logic              w_hit, w_coal, w_full, w_rd_miss, w_wr_req, w_alloc, w_retire;
  logic [DATA_W-1:0] w_hit_data;
  logic [PTR_W-1:0]  w_coal_idx, w_idx;

  // Walk oldest to youngest so the last match is the youngest copy.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_coal     = 1'b0;
    w_coal_idx = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && r_addr[w_idx] == bus.MEM_ADDRESS) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_idx];
        if (!(r_state == S_DRAIN && w_idx == r_head)) begin
          w_coal     = 1'b1;
          w_coal_idx = w_idx;
        end
      end
    end
  end

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_rd_miss = bus.MEM_READ && !w_hit;
  assign w_wr_req  = bus.MEM_WRITE && !bus.MEM_READ;
  assign w_alloc   = w_wr_req && !w_coal && !w_full;
  assign w_retire  = (r_state == S_DRAIN) && !bus.DM_BUSYWAIT;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_miss)           w_next = S_RD;
        else if (r_count != '0)  w_next = S_DRAIN;
      end
      S_DRAIN:   if (!bus.DM_BUSYWAIT) w_next = S_IDLE;
      S_RD:      if (!bus.DM_BUSYWAIT) w_next = S_RD_DONE;
      S_RD_DONE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_rd_addr <= '0;
      r_rdata   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_rd_miss) r_rd_addr <= bus.MEM_ADDRESS;
      if (r_state == S_RD && !bus.DM_BUSYWAIT) r_rdata <= bus.DM_READDATA;
      if (w_wr_req && w_coal) r_data[w_coal_idx] <= bus.MEM_WRITEDATA;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.MEM_ADDRESS;
        r_data[r_tail]  <= bus.MEM_WRITEDATA;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc && !w_retire)      r_count <= r_count + CNT_W'(1);
      else if (!w_alloc && w_retire) r_count <= r_count - CNT_W'(1);
    end
  end

  // Drain data is read live from the head so a same-edge coalesce is never lost.
  always_comb begin
    bus.MEM_BUSYWAIT = 1'b0;
    if (bus.MEM_READ)       bus.MEM_BUSYWAIT = !w_hit && (r_state != S_RD_DONE);
    else if (bus.MEM_WRITE) bus.MEM_BUSYWAIT = !w_coal && w_full;
  end

  assign bus.MEM_READDATA = (bus.MEM_READ && w_hit) ? w_hit_data : r_rdata;
  assign bus.DM_READ      = (r_state == S_RD);
  assign bus.DM_WRITE     = (r_state == S_DRAIN);
  assign bus.DM_ADDRESS   = (r_state == S_DRAIN) ? r_addr[r_head] :
                            (r_state == S_RD)    ? r_rd_addr : '0;
  assign bus.DM_WRITEDATA = (r_state == S_DRAIN) ? r_data[r_head] : '0;
  assign bus.WB_COUNT     = r_count;
  assign bus.WB_EMPTY     = (r_count == '0);
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - directed self-checking bench for dcache_write_buffer
// A latency-3 memory model logs every completed downstream access in order.
module tb_dcache_write_buffer;
  localparam int LAT = 3;

  logic CLK;
  logic RESET;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  dcache_write_buffer_if #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) bus ();

  dcache_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [64];
  bit          mem_v [64];
  int          lat_cnt = 0;
  int          ev_n = 0;
  bit          ev_wr [256];
  logic [5:0]  ev_addr [256];
  logic [31:0] ev_data [256];

  assign bus.DM_BUSYWAIT = (bus.DM_READ || bus.DM_WRITE) && (lat_cnt != LAT);
  assign bus.DM_READDATA = mem_v[bus.DM_ADDRESS] ? mem[bus.DM_ADDRESS]
                                                 : (32'hD0D0_0000 | {26'd0, bus.DM_ADDRESS});

  always @(posedge CLK) begin
    if (bus.DM_READ || bus.DM_WRITE) begin
      if (lat_cnt == LAT) begin
        lat_cnt <= 0;
        if (bus.DM_WRITE) begin
          mem[bus.DM_ADDRESS]   <= bus.DM_WRITEDATA;
          mem_v[bus.DM_ADDRESS] <= 1'b1;
        end
        if (ev_n < 256) begin
          ev_wr[ev_n]   <= bus.DM_WRITE;
          ev_addr[ev_n] <= bus.DM_ADDRESS;
          ev_data[ev_n] <= bus.DM_WRITE ? bus.DM_WRITEDATA : bus.DM_READDATA;
        end
        ev_n <= ev_n + 1;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  task automatic cache_write(input logic [5:0] a, input logic [31:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    bus.MEM_WRITE = 1'b1; bus.MEM_READ = 1'b0; bus.MEM_ADDRESS = a; bus.MEM_WRITEDATA = d;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.MEM_BUSYWAIT) begin ok = 1'b1; break; end
      @(negedge CLK);
      stalls++;
    end
    total_cnt++;
    if (!ok) $display("FAIL write_timeout addr=%0h got=stalled exp=accepted", a); else pass_cnt++;
    @(negedge CLK);
    bus.MEM_WRITE = 1'b0;
  endtask

  task automatic cache_read(input logic [5:0] a, output logic [31:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    d = '0;
    bus.MEM_READ = 1'b1; bus.MEM_WRITE = 1'b0; bus.MEM_ADDRESS = a;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.MEM_BUSYWAIT) begin ok = 1'b1; d = bus.MEM_READDATA; break; end
      @(negedge CLK);
      stalls++;
    end
    total_cnt++;
    if (!ok) $display("FAIL read_timeout addr=%0h got=stalled exp=served", a); else pass_cnt++;
    @(negedge CLK);
    bus.MEM_READ = 1'b0;
  endtask

  task automatic wait_dm_write();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); #1;
      if (bus.DM_WRITE) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL dm_write_timeout got=0 exp=1"); else pass_cnt++;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK); #1;
      if (bus.WB_EMPTY && !bus.DM_WRITE && !bus.DM_READ) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL empty_timeout count=%0d exp=0", bus.WB_COUNT); else pass_cnt++;
  endtask

  task automatic test_reset();
    int n0, st;
    bus.MEM_READ = 1'b0; bus.MEM_WRITE = 1'b0; bus.MEM_ADDRESS = '0; bus.MEM_WRITEDATA = '0;
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    total_cnt++; if (bus.MEM_BUSYWAIT !== 1'b0) $display("FAIL rst_busywait got=%0h exp=0", bus.MEM_BUSYWAIT); else pass_cnt++;
    total_cnt++; if (bus.MEM_READDATA !== 32'h0) $display("FAIL rst_readdata got=%0h exp=0", bus.MEM_READDATA); else pass_cnt++;
    total_cnt++; if (bus.DM_READ !== 1'b0) $display("FAIL rst_dm_read got=%0h exp=0", bus.DM_READ); else pass_cnt++;
    total_cnt++; if (bus.DM_WRITE !== 1'b0) $display("FAIL rst_dm_write got=%0h exp=0", bus.DM_WRITE); else pass_cnt++;
    total_cnt++; if (bus.DM_ADDRESS !== 6'h0) $display("FAIL rst_dm_address got=%0h exp=0", bus.DM_ADDRESS); else pass_cnt++;
    total_cnt++; if (bus.DM_WRITEDATA !== 32'h0) $display("FAIL rst_dm_writedata got=%0h exp=0", bus.DM_WRITEDATA); else pass_cnt++;
    total_cnt++; if (bus.WB_COUNT !== 3'd0) $display("FAIL rst_count got=%0d exp=0", bus.WB_COUNT); else pass_cnt++;
    total_cnt++; if (bus.WB_EMPTY !== 1'b1) $display("FAIL rst_empty got=%0h exp=1", bus.WB_EMPTY); else pass_cnt++;
    cache_write(6'h05, 32'h5555_AAAA, st);
    wait_dm_write();
    n0 = ev_n;
    RESET = 1'b0;
    #1;
    total_cnt++; if (bus.DM_WRITE !== 1'b0) $display("FAIL midrst_dm_write got=%0h exp=0", bus.DM_WRITE); else pass_cnt++;
    total_cnt++; if (bus.WB_COUNT !== 3'd0) $display("FAIL midrst_count got=%0d exp=0", bus.WB_COUNT); else pass_cnt++;
    total_cnt++; if (bus.WB_EMPTY !== 1'b1) $display("FAIL midrst_empty got=%0h exp=1", bus.WB_EMPTY); else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    total_cnt++; if (ev_n !== n0) $display("FAIL midrst_no_write got=%0d exp=%0d", ev_n, n0); else pass_cnt++;
    total_cnt++; if (mem_v[5] !== 1'b0) $display("FAIL midrst_mem05 got=%0h exp=0", mem_v[5]); else pass_cnt++;
  endtask

  task automatic test_read_hit();
    int n0, st;
    n0 = ev_n;
    cache_write(6'h05, 32'hAABB_CCDD, st);
    bus.MEM_READ = 1'b1; bus.MEM_ADDRESS = 6'h05;
    #1;
    total_cnt++; if (bus.MEM_BUSYWAIT !== 1'b0) $display("FAIL hit_busywait got=%0h exp=0", bus.MEM_BUSYWAIT); else pass_cnt++;
    total_cnt++; if (bus.MEM_READDATA !== 32'hAABB_CCDD) $display("FAIL hit_data got=%0h exp=aabbccdd", bus.MEM_READDATA); else pass_cnt++;
    total_cnt++; if (bus.DM_READ !== 1'b0) $display("FAIL hit_dm_read got=%0h exp=0", bus.DM_READ); else pass_cnt++;
    @(negedge CLK);
    bus.MEM_READ = 1'b0;
    wait_empty();
    total_cnt++; if (ev_n !== n0 + 1) $display("FAIL hit_events got=%0d exp=%0d", ev_n, n0 + 1); else pass_cnt++;
    total_cnt++; if (ev_wr[n0] !== 1'b1 || ev_addr[n0] !== 6'h05) $display("FAIL hit_drain got=wr%0h/%0h exp=wr1/05", ev_wr[n0], ev_addr[n0]); else pass_cnt++;
    total_cnt++; if (mem[5] !== 32'hAABB_CCDD) $display("FAIL hit_mem05 got=%0h exp=aabbccdd", mem[5]); else pass_cnt++;
  endtask

  task automatic test_coalesce();
    int n0, st;
    n0 = ev_n;
    cache_write(6'h01, 32'h0101_0101, st);
    wait_dm_write();
    cache_write(6'h09, 32'h1111_1111, st);
    cache_write(6'h09, 32'h2222_2222, st);
    #1;
    total_cnt++; if (bus.WB_COUNT !== 3'd2) $display("FAIL coal_count got=%0d exp=2", bus.WB_COUNT); else pass_cnt++;
    wait_empty();
    total_cnt++; if (ev_n !== n0 + 2) $display("FAIL coal_events got=%0d exp=%0d", ev_n, n0 + 2); else pass_cnt++;
    total_cnt++; if (ev_addr[n0] !== 6'h01) $display("FAIL coal_first got=%0h exp=01", ev_addr[n0]); else pass_cnt++;
    total_cnt++; if (ev_addr[n0+1] !== 6'h09) $display("FAIL coal_second got=%0h exp=09", ev_addr[n0+1]); else pass_cnt++;
    total_cnt++; if (mem[9] !== 32'h2222_2222) $display("FAIL coal_mem09 got=%0h exp=22222222", mem[9]); else pass_cnt++;
  endtask

  task automatic test_full_stall();
    int n0, st;
    n0 = ev_n;
    for (int i = 0; i < 4; i++) cache_write(6'h10 + 6'(i), 32'hF000_0010 + 32'(i), st);
    #1;
    total_cnt++; if (bus.WB_COUNT !== 3'd4) $display("FAIL full_count got=%0d exp=4", bus.WB_COUNT); else pass_cnt++;
    cache_write(6'h14, 32'hF000_0014, st);
    total_cnt++; if (st !== 2) $display("FAIL full_stalls got=%0d exp=2", st); else pass_cnt++;
    total_cnt++; if (ev_n !== n0 + 1) $display("FAIL full_retired got=%0d exp=%0d", ev_n, n0 + 1); else pass_cnt++;
    wait_empty();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (ev_wr[n0+i] !== 1'b1 || ev_addr[n0+i] !== 6'h10 + 6'(i) || ev_data[n0+i] !== 32'hF000_0010 + 32'(i))
        $display("FAIL full_order%0d got=%0h/%0h exp=%0h/%0h", i, ev_addr[n0+i], ev_data[n0+i], 6'h10 + 6'(i), 32'hF000_0010 + 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_read_priority();
    int n0, st;
    logic [31:0] d;
    n0 = ev_n;
    cache_write(6'h20, 32'h2020_2020, st);
    cache_read(6'h30, d, st);
    total_cnt++; if (d !== 32'hD0D0_0030) $display("FAIL prio_data got=%0h exp=d0d00030", d); else pass_cnt++;
    total_cnt++; if (st !== 5) $display("FAIL prio_stalls got=%0d exp=5", st); else pass_cnt++;
    wait_empty();
    total_cnt++; if (ev_wr[n0] !== 1'b0 || ev_addr[n0] !== 6'h30) $display("FAIL prio_first got=wr%0h/%0h exp=wr0/30", ev_wr[n0], ev_addr[n0]); else pass_cnt++;
    total_cnt++; if (ev_wr[n0+1] !== 1'b1 || ev_addr[n0+1] !== 6'h20) $display("FAIL prio_second got=wr%0h/%0h exp=wr1/20", ev_wr[n0+1], ev_addr[n0+1]); else pass_cnt++;
  endtask

  task automatic test_read_during_drain();
    int n0, st;
    logic [31:0] d;
    n0 = ev_n;
    cache_write(6'h20, 32'h2A2A_2A2A, st);
    wait_dm_write();
    cache_read(6'h31, d, st);
    total_cnt++; if (d !== 32'hD0D0_0031) $display("FAIL rdd_data got=%0h exp=d0d00031", d); else pass_cnt++;
    total_cnt++; if (st !== 9) $display("FAIL rdd_stalls got=%0d exp=9", st); else pass_cnt++;
    total_cnt++; if (ev_wr[n0] !== 1'b1 || ev_addr[n0] !== 6'h20 || ev_data[n0] !== 32'h2A2A_2A2A) $display("FAIL rdd_first got=wr%0h/%0h exp=wr1/20", ev_wr[n0], ev_addr[n0]); else pass_cnt++;
    total_cnt++; if (ev_wr[n0+1] !== 1'b0 || ev_addr[n0+1] !== 6'h31) $display("FAIL rdd_second got=wr%0h/%0h exp=wr0/31", ev_wr[n0+1], ev_addr[n0+1]); else pass_cnt++;
  endtask

  task automatic test_youngest_hit();
    int n0, st;
    n0 = ev_n;
    cache_write(6'h2C, 32'h0000_00C1, st);
    wait_dm_write();
    cache_write(6'h2C, 32'h0000_00C2, st);
    bus.MEM_READ = 1'b1; bus.MEM_ADDRESS = 6'h2C;
    #1;
    total_cnt++; if (bus.WB_COUNT !== 3'd2) $display("FAIL young_count got=%0d exp=2", bus.WB_COUNT); else pass_cnt++;
    total_cnt++; if (bus.MEM_READDATA !== 32'h0000_00C2) $display("FAIL young_data got=%0h exp=c2", bus.MEM_READDATA); else pass_cnt++;
    @(negedge CLK);
    bus.MEM_READ = 1'b0;
    wait_empty();
    total_cnt++; if (ev_data[n0] !== 32'h0000_00C1 || ev_data[n0+1] !== 32'h0000_00C2) $display("FAIL young_drains got=%0h,%0h exp=c1,c2", ev_data[n0], ev_data[n0+1]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_coalesce();
    test_full_stall();
    test_read_priority();
    test_read_during_drain();
    test_youngest_hit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Posted-write FIFO inserted between `dcache` and `data_memory`. It absorbs dirty-block writebacks in one cycle, so the cache can start its refill immediately. Buffered blocks drain to memory in the background. Block reads are checked against buffered entries and forwarded on a hit; otherwise they go to memory ahead of pending drains. The cache-side ports mirror the `data_memory` port set, so the block drops in without changing `dcache`.

## Interface
- DEPTH, 4, number of buffered block entries (power of 2, ≥2)
- ADDR_W, 6, block address width
- DATA_W, 32, block data width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- MEM_READ  in  1  cache block-read request, held until busywait low
- MEM_WRITE  in  1  cache block-write request, held until busywait low
- MEM_ADDRESS  in  ADDR_W  cache block address
- MEM_WRITEDATA  in  DATA_W  cache writeback block
- MEM_READDATA  out  DATA_W  block returned to cache
- MEM_BUSYWAIT  out  1  stall to cache
- DM_READ  out  1  read request to data_memory
- DM_WRITE  out  1  write request to data_memory
- DM_ADDRESS  out  ADDR_W  address to data_memory
- DM_WRITEDATA  out  DATA_W  write data to data_memory
- DM_READDATA  in  DATA_W  read data from data_memory
- DM_BUSYWAIT  in  1  data_memory busy
- WB_COUNT  out  clog2(DEPTH)+1  valid entries
- WB_EMPTY  out  1  WB_COUNT==0

## Operation
- Storage is a circular FIFO of DEPTH entries, each {valid, addr, data}.
  - head = oldest entry; tail = next free slot.
  - Pointers wrap modulo DEPTH. Full when COUNT==DEPTH.
- Cache write (MEM_WRITE=1, MEM_READ=0):
  - Coalesce: if the address matches a valid entry that is not the entry currently draining, overwrite that entry's data in place. COUNT is unchanged.
  - Otherwise, if not full: allocate at tail and increment COUNT.
  - If full with no coalesce target: MEM_BUSYWAIT=1 until a slot frees.
- Cache read (MEM_READ=1):
  - Hit (address matches any valid entry): MEM_READDATA = data of the youngest matching entry. MEM_BUSYWAIT=0 combinationally (zero-wait forward).
  - Miss: a downstream read is issued. MEM_BUSYWAIT=1 until the read-done cycle.
- Downstream FSM states: IDLE, DRAIN, RD, RD_DONE.
  - IDLE → RD when a read miss is pending; reads take priority over drains.
  - IDLE → DRAIN when COUNT>0 and no read miss is pending. Drives DM_WRITE with the head entry.
  - DRAIN → IDLE on a completion edge. Head is retired and COUNT decrements.
  - RD → RD_DONE on a completion edge. DM_READDATA is latched into MEM_READDATA.
  - RD_DONE → IDLE after exactly 1 cycle. During RD_DONE, MEM_BUSYWAIT=0.
- A read miss arriving during DRAIN waits for the drain to finish; drains are never aborted. Bypassing older writes is safe because the read address matches no entry.
- Completion edge: a rising edge with DM_READ or DM_WRITE asserted and DM_BUSYWAIT=0. DM_READ/DM_WRITE deassert on that same edge.
- Same-edge retire and allocate is allowed: COUNT is unchanged and both pointers advance.
- Full is evaluated on the pre-edge COUNT. A write into a full buffer stalls even if the head retires on that edge.
- MEM_READ and MEM_WRITE both high is illegal. Read wins and the write is ignored.

## Timing
- Reset values: MEM_BUSYWAIT=0, MEM_READDATA=0, DM_READ=0, DM_WRITE=0, DM_ADDRESS=0, DM_WRITEDATA=0, WB_COUNT=0, WB_EMPTY=1, FSM=IDLE, all valid=0, head=tail=0.
- Reset mid-operation clears all state immediately. In-flight downstream transactions and buffered data are dropped.
- Write accept latency: 0 stall cycles when not full. The entry is captured on the next rising edge.
- Read hit latency: 0 stall cycles.
- Read miss latency: memory latency + 1 cycle (RD_DONE). The cache samples data on the RD_DONE edge.
- Drain of an entry starts at the earliest 1 cycle after allocation.

## Test plan
- Reset: assert RESET=0 mid-drain → DM_WRITE=0, WB_COUNT=0, WB_EMPTY=1 within the same time step; no write reaches memory afterwards.
- Write then read-hit: write addr 0x05 data 0xAABBCCDD, then read 0x05 before the drain completes → MEM_BUSYWAIT=0, MEM_READDATA=0xAABBCCDD, no DM_READ issued.
- Coalesce: two writes to 0x09 (0x11111111, then 0x22222222) while the head is busy with 0x01 → WB_COUNT=2 and memory[0x09] ends at 0x22222222 after a single DM_WRITE.
- Full stall: fill DEPTH=4 entries (0x10–0x13) and write 0x14 → MEM_BUSYWAIT=1 until the first drain completion; 0x14 is accepted on the following edge; drain order is 0x10,0x11,0x12,0x13,0x14.
- Read priority: buffer holds 0x20; read miss 0x30 arrives while IDLE → DM_READ issued before DM_WRITE 0x20; MEM_READDATA equals the memory[0x30] value in RD_DONE.
- Read during drain: read miss 0x31 arrives mid-DRAIN of 0x20 → DM_WRITE completes first, then DM_READ 0x31; the cache sees MEM_BUSYWAIT=1 throughout until RD_DONE.
